// File: rtl/proj_pkg.sv
// Shared widths and FSM state type for the fragment min-hash scanner.
package proj_pkg;

   localparam int FM_EXTENDER_FRAG_LEN_BITS = 16;
   localparam int SIGNED_INDICE_LEN         = 8;
   localparam int MH_HASH_BITS              = 8;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN,
      OUT
   } mh_state_t;

endpackage

// File: rtl/proj_frag_hash.sv
// Combinational fragment hash: XOR-fold into HASH_BITS chunks, then fold*a + b
// truncated to HASH_BITS.
module proj_frag_hash #(
   parameter int FRAG_LEN  = proj_pkg::FM_EXTENDER_FRAG_LEN_BITS,
   parameter int HASH_BITS = proj_pkg::MH_HASH_BITS
) (
   input  logic [FRAG_LEN-1:0]  frag,
   input  logic [HASH_BITS-1:0] seed_a,
   input  logic [HASH_BITS-1:0] seed_b,
   output logic [HASH_BITS-1:0] hash
);

   localparam int CHUNKS = (FRAG_LEN + HASH_BITS - 1) / HASH_BITS;

   logic [CHUNKS*HASH_BITS-1:0] padded;
   logic [HASH_BITS-1:0]        fold;

   // The top chunk is zero-padded so a partial chunk folds in cleanly.
   always_comb begin
      padded                = '0;
      padded[FRAG_LEN-1:0]  = frag;
      fold                  = '0;
      for (int i = 0; i < CHUNKS; i++) begin
         fold = fold ^ padded[i*HASH_BITS +: HASH_BITS];
      end
   end

   assign hash = fold * seed_a + seed_b;

endmodule

// File: rtl/proj_frag_minhash.sv
// Scans a signed index range of the feature memory and reports the minimum
// fragment hash and its index through a valid/ready result port.
module proj_frag_minhash #(
   parameter int FRAG_LEN          = proj_pkg::FM_EXTENDER_FRAG_LEN_BITS,
   parameter int SIGNED_INDICE_LEN = proj_pkg::SIGNED_INDICE_LEN,
   parameter int HASH_BITS         = proj_pkg::MH_HASH_BITS
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [SIGNED_INDICE_LEN-1:0] idx_first,
   input  logic [SIGNED_INDICE_LEN-1:0] idx_last,
   input  logic [HASH_BITS-1:0]         seed_a,
   input  logic [HASH_BITS-1:0]         seed_b,
   output logic [SIGNED_INDICE_LEN-1:0] frag_idx,
   input  logic [FRAG_LEN-1:0]          frag_rdata,
   output logic                         busy,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [HASH_BITS-1:0]         out_min_hash,
   output logic [SIGNED_INDICE_LEN-1:0] out_min_idx,
   output logic                         scan_done
);

   import proj_pkg::*;

   mh_state_t                    state;
   logic                         drain_cnt;
   logic [SIGNED_INDICE_LEN-1:0] last_r;
   logic [HASH_BITS-1:0]         a_r;
   logic [HASH_BITS-1:0]         b_r;

   logic                         s1_valid;
   logic [FRAG_LEN-1:0]          s1_data;
   logic [SIGNED_INDICE_LEN-1:0] s1_idx;
   logic                         s2_valid;
   logic [HASH_BITS-1:0]         s2_hash;
   logic [SIGNED_INDICE_LEN-1:0] s2_idx;
   logic [HASH_BITS-1:0]         hash_c;

   proj_frag_hash #(
      .FRAG_LEN  (FRAG_LEN),
      .HASH_BITS (HASH_BITS)
   ) u_hash (
      .frag   (s1_data),
      .seed_a (a_r),
      .seed_b (b_r),
      .hash   (hash_c)
   );

   // Two-stage capture/hash pipeline; only SCAN cycles carry valid data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_idx   <= '0;
         s2_valid <= 1'b0;
         s2_hash  <= '0;
         s2_idx   <= '0;
      end else begin
         s1_valid <= (state == SCAN);
         s1_data  <= frag_rdata;
         s1_idx   <= frag_idx;
         s2_valid <= s1_valid;
         s2_hash  <= hash_c;
         s2_idx   <= s2_idx_next(s1_idx);
      end
   end

   function automatic logic [SIGNED_INDICE_LEN-1:0] s2_idx_next(
      input logic [SIGNED_INDICE_LEN-1:0] idx);
      return idx;
   endfunction

   // Control FSM plus the min registers; DRAIN covers the two pipeline stages
   // so the last min update lands on the same edge that raises out_valid.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         drain_cnt    <= 1'b0;
         last_r       <= '0;
         a_r          <= '0;
         b_r          <= '0;
         frag_idx     <= '0;
         busy         <= 1'b0;
         out_valid    <= 1'b0;
         scan_done    <= 1'b0;
         out_min_hash <= '1;
         out_min_idx  <= '0;
      end else begin
         scan_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_r          <= seed_a;
                  b_r          <= seed_b;
                  last_r       <= idx_last;
                  out_min_hash <= '1;
                  out_min_idx  <= idx_first;
                  busy         <= 1'b1;
                  if ($signed(idx_first) > $signed(idx_last)) begin
                     state     <= OUT;
                     out_valid <= 1'b1;
                  end else begin
                     state    <= SCAN;
                     frag_idx <= idx_first;
                  end
               end
            end
            SCAN: begin
               if (frag_idx == last_r) begin
                  state     <= DRAIN;
                  frag_idx  <= '0;
                  drain_cnt <= 1'b0;
               end else begin
                  frag_idx <= frag_idx + 1'b1;
               end
            end
            DRAIN: begin
               if (drain_cnt) begin
                  state     <= OUT;
                  out_valid <= 1'b1;
               end else begin
                  drain_cnt <= 1'b1;
               end
            end
            OUT: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  scan_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
         if (s2_valid && (s2_hash < out_min_hash)) begin
            out_min_hash <= s2_hash;
            out_min_idx  <= s2_idx;
         end
      end
   end

endmodule

// File: tb/tb_proj_frag_minhash.sv
// Randomized and directed bench for proj_frag_minhash, checked against a
// plain-arithmetic model of the range min-hash.
module tb_proj_frag_minhash;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  idx_first = '0;
   logic [7:0]  idx_last = '0;
   logic [7:0]  seed_a = '0;
   logic [7:0]  seed_b = '0;
   logic [7:0]  frag_idx;
   logic [15:0] frag_rdata;
   logic        busy;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  out_min_hash;
   logic [7:0]  out_min_idx;
   logic        scan_done;

   logic [15:0] mem [256];
   logic [7:0]  exp_hash = '0;
   logic [7:0]  exp_idx = '0;
   logic [7:0]  got_hash = '0;
   logic [7:0]  got_idx = '0;
   logic        check_en = 1'b0;
   logic        hs_prev = 1'b0;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   assign frag_rdata = mem[frag_idx];

   proj_frag_minhash #(
      .FRAG_LEN          (16),
      .SIGNED_INDICE_LEN (8),
      .HASH_BITS         (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .idx_first    (idx_first),
      .idx_last     (idx_last),
      .seed_a       (seed_a),
      .seed_b       (seed_b),
      .frag_idx     (frag_idx),
      .frag_rdata   (frag_rdata),
      .busy         (busy),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_min_hash (out_min_hash),
      .out_min_idx  (out_min_idx),
      .scan_done    (scan_done)
   );

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int model_hash(input int data, input int a, input int b);
      int f;
      f = 0;
      for (int sh = 0; sh < 16; sh += 8) f = f ^ ((data >> sh) & 255);
      return (f * a + b) % 256;
   endfunction

   // A completed handshake on one edge must show up as scan_done after it.
   always @(posedge clk) hs_prev <= rst_n && out_valid && out_ready;

   always @(negedge clk) begin
      if (check_en) begin
         check_output("scan_done", {31'b0, scan_done}, {31'b0, hs_prev});
         if (!busy) check_output("idle_frag_idx", {24'b0, frag_idx}, 32'h0);
         if (out_valid) begin
            check_output("out_min_hash", {24'b0, out_min_hash}, {24'b0, exp_hash});
            check_output("out_min_idx", {24'b0, out_min_idx}, {24'b0, exp_idx});
         end
      end
   end

   task automatic apply_stimulus(input int first, input int last, input int a, input int b,
                                 input int ready_delay, input bit poke_start, input string tag);
      int n, lat, best, bidx, h;
      n = (last >= first) ? last - first + 1 : 0;
      best = 255;
      bidx = first;
      for (int i = first; i <= last; i++) begin
         h = model_hash(int'(mem[8'(i)]), a, b);
         if (h < best) begin
            best = h;
            bidx = i;
         end
      end
      exp_hash = 8'(best);
      exp_idx  = 8'(bidx);
      @(negedge clk);
      idx_first = 8'(first);
      idx_last  = 8'(last);
      seed_a    = 8'(a);
      seed_b    = 8'(b);
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      if (n == 0) check_output({tag, "_empty_frag_idx"}, {24'b0, frag_idx}, 32'h0);
      while (!out_valid && lat < 300) begin
         if (lat < n) check_output({tag, "_frag_idx"}, {24'b0, frag_idx}, {24'b0, 8'(first + lat)});
         @(negedge clk);
         lat++;
      end
      check_output({tag, "_latency"}, lat, (n == 0) ? 0 : n + 2);
      got_hash = out_min_hash;
      got_idx  = out_min_idx;
      for (int d = 0; d < ready_delay; d++) begin
         start = poke_start;
         @(negedge clk);
         check_output({tag, "_hold_valid"}, {31'b0, out_valid}, 32'h1);
         check_output({tag, "_hold_hash"}, {24'b0, out_min_hash}, {24'b0, got_hash});
         check_output({tag, "_hold_idx"}, {24'b0, out_min_idx}, {24'b0, got_idx});
      end
      start     = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_output({tag, "_post_valid"}, {31'b0, out_valid}, 32'h0);
      check_output({tag, "_post_busy"}, {31'b0, busy}, 32'h0);
      check_output({tag, "_post_done"}, {31'b0, scan_done}, 32'h1);
      @(negedge clk);
      check_output({tag, "_done_once"}, {31'b0, scan_done}, 32'h0);
   endtask

   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check_output("rst_busy", {31'b0, busy}, 32'h0);
      check_output("rst_valid", {31'b0, out_valid}, 32'h0);
      check_output("rst_done", {31'b0, scan_done}, 32'h0);
      check_output("rst_frag_idx", {24'b0, frag_idx}, 32'h0);
      check_output("rst_min_hash", {24'b0, out_min_hash}, 32'hFF);
      check_output("rst_min_idx", {24'b0, out_min_idx}, 32'h0);
      check_en = 1'b1;

      mem[8'hFE] = 16'h1234;
      mem[8'hFF] = 16'h00FF;
      mem[8'h00] = 16'h0F0F;
      mem[8'h01] = 16'h8001;
      apply_stimulus(-2, 1, 1, 0, 0, 1'b0, "basic");
      check_output("basic_hash_lit", {24'b0, got_hash}, 32'h00);
      check_output("basic_idx_lit", {24'b0, got_idx}, 32'h00);

      for (int i = -2; i <= 1; i++) mem[8'(i)] = 16'h0101;
      apply_stimulus(-2, 1, 1, 0, 1, 1'b0, "tie");
      check_output("tie_hash_lit", {24'b0, got_hash}, 32'h00);
      check_output("tie_idx_lit", {24'b0, got_idx}, 32'hFE);

      mem[5] = 16'h0030;
      apply_stimulus(5, 5, 3, 8'hF0, 0, 1'b0, "wrap");
      check_output("wrap_hash_lit", {24'b0, got_hash}, 32'h80);
      check_output("wrap_idx_lit", {24'b0, got_idx}, 32'h05);

      apply_stimulus(3, 2, 7, 9, 0, 1'b0, "empty");
      check_output("empty_hash_lit", {24'b0, got_hash}, 32'hFF);
      check_output("empty_idx_lit", {24'b0, got_idx}, 32'h03);

      for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
      apply_stimulus(-3, 4, 5, 17, 5, 1'b1, "bp");

      // Reset lands two cycles into a ten-index scan.
      @(negedge clk);
      idx_first = 8'd0;
      idx_last  = 8'd9;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_output("mrst_busy", {31'b0, busy}, 32'h0);
      check_output("mrst_valid", {31'b0, out_valid}, 32'h0);
      check_output("mrst_frag_idx", {24'b0, frag_idx}, 32'h0);
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         check_output("mrst_no_valid", {31'b0, out_valid}, 32'h0);
         check_output("mrst_no_done", {31'b0, scan_done}, 32'h0);
      end
      apply_stimulus(0, 9, 3, 1, 0, 1'b0, "mrst_rescan");

      for (int t = 0; t < 25; t++) begin
         int first, len;
         for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
         first = int'($urandom_range(0, 40)) - 20;
         len   = int'($urandom_range(0, 12)) - 1;
         apply_stimulus(first, first + len - 1 + ((len < 0) ? 0 : 0) + ((len == 0) ? 0 : 0),
                        int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                        int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1), "rand");
      end

      check_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/proj_frag_minhash.md
PROJ_FRAG_MINHASH -- requirements
Module: proj_frag_minhash

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- FRAG_LEN, proj_pkg::FM_EXTENDER_FRAG_LEN_BITS, fragment width in bits.
- SIGNED_INDICE_LEN, proj_pkg::SIGNED_INDICE_LEN, signed fragment index width.
- HASH_BITS, proj_pkg::MH_HASH_BITS, hash width.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  scan request, accepted only in IDLE.
- idx_first  in  SIGNED_INDICE_LEN  first index, signed, sampled at start.
- idx_last  in  SIGNED_INDICE_LEN  last index, signed, inclusive, sampled at start.
- seed_a  in  HASH_BITS  hash multiplier, sampled at start.
- seed_b  in  HASH_BITS  hash addend, sampled at start.
- frag_idx  out  SIGNED_INDICE_LEN  index presented to the feature memory.
- frag_rdata  in  FRAG_LEN  fragment from the feature memory, valid in the same cycle as frag_idx.
- busy  out  1  high when not in IDLE.
- out_valid  out  1  result available.
- out_ready  in  1  result consumed.
- out_min_hash  out  HASH_BITS  minimum hash.
- out_min_idx  out  SIGNED_INDICE_LEN  index of the minimum hash.
- scan_done  out  1  one-cycle pulse on result handshake; drives the feature-memory buffer swap (chg_idx).

Function
REQ-003 FSM states SHALL be IDLE, SCAN, DRAIN and OUT.
REQ-004 IDLE->SCAN on start=1; the block SHALL sample idx_first, idx_last, seed_a and seed_b on that edge.
REQ-005 If the sampled idx_first > idx_last (signed compare), the block SHALL go IDLE->OUT with out_min_hash all-ones and out_min_idx=idx_first.
REQ-006 In SCAN, frag_idx SHALL equal idx_first+k in the k-th cycle after acceptance, incrementing by 1 per cycle.
REQ-007 SCAN->DRAIN SHALL occur after idx_last is issued.
REQ-008 DRAIN SHALL last exactly 2 cycles, then go to OUT.
REQ-009 Pipeline: stage 1 SHALL register frag_rdata and frag_idx with a valid bit; stage 2 SHALL register the hash, index and valid; stage 3 SHALL update the min registers.
REQ-010 Fold: frag_rdata SHALL be split into HASH_BITS chunks from the LSB, with the top chunk zero-padded, and all chunks XORed together.
REQ-011 Hash SHALL be (fold*seed_a + seed_b) mod 2^HASH_BITS, discarding overflow.
REQ-012 Min update SHALL use strict less-than, so on a tie the lowest index wins.
REQ-013 Min registers SHALL initialise to all-ones and idx_first at start acceptance.
REQ-014 For N = idx_last-idx_first+1 >= 1, out_valid SHALL rise on the (N+2)-th rising edge after the start-accepting edge.
REQ-015 In OUT, out_valid=1 and out_min_hash/out_min_idx SHALL hold stable until out_ready=1.
REQ-016 On the out_valid & out_ready edge, the block SHALL go to IDLE and scan_done SHALL be 1 for exactly the following cycle.
REQ-017 start SHALL be ignored while busy, including while start is held high.
REQ-018 frag_idx SHALL be 0 outside SCAN.
REQ-019 Index arithmetic SHALL be SIGNED_INDICE_LEN two's complement; negative indices SHALL pass through unchanged (padding is owned by the feature memory).

Reset
REQ-020 With rst_n=0 at an edge: state=IDLE, all pipeline valids=0, out_valid=0, busy=0, scan_done=0, frag_idx=0, out_min_hash=all-ones, out_min_idx=0.
REQ-021 Reset SHALL take priority over every other event, including mid-SCAN and mid-OUT; no scan_done pulse SHALL follow.

Structure
REQ-022 proj_pkg SHALL hold MH_HASH_BITS and the FSM state typedef (mh_state_t).
REQ-023 Fold plus multiply-add SHALL be a combinational sub-module, proj_frag_hash.
REQ-024 The block SHALL contain no memories; it SHALL connect directly to the feature memory's frag_idx/out_rdata ports.

Verification (bench: FRAG_LEN=16, HASH_BITS=8, SIGNED_INDICE_LEN=8)
REQ-025 Basic: range -2..1, memory model returns 0x1234, 0x00FF, 0x0F0F, 0x8001, seeds a=1, b=0 -> folds 0x26, 0xFF, 0x00, 0x81; out_min_hash=0x00, out_min_idx=0; out_valid on the 6th edge after start.
REQ-026 Tie: range -2..1, all fragments 0x0101 -> out_min_hash=0x00, out_min_idx=-2 (0xFE).
REQ-027 Wrap: single index 5, fragment 0x0030, a=3, b=0xF0 -> out_min_hash=0x80, out_min_idx=5.
REQ-028 Empty: idx_first=3, idx_last=2 -> out_valid on the next edge, out_min_hash=0xFF, out_min_idx=3, no frag_idx activity.
REQ-029 Backpressure: out_ready low 5 cycles with start pulsed meanwhile -> outputs stable, start ignored, scan_done pulses once after the handshake.
REQ-030 Reset mid-SCAN: rst_n low 1 cycle at k=2 of a 10-index scan -> IDLE, busy=0, no out_valid or scan_done; a new start afterwards gives a correct result.
